// File: rtl/arm_muldiv_unit.sv
// Iterative multiply/divide coprocessor: one shift-add or restoring-subtract step per cycle.
// Define ARM_MULDIV_DIV_EN to include the UDIV/SDIV datapath; otherwise divide ops report illegal.
module arm_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [3:0]       flags_o,
  output logic             divzero_o,
  output logic             illegal_o
);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_UMULL = 2'b01;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(1);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_FIN = 2'b10, S_DONE = 2'b11} state_t;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] mcand_q, hi_q, lo_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, divzero_q, illegal_q;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;
  logic [3:0]       flags_q;

  logic [WIDTH-1:0] step_hi_d, step_lo_d, fin_lo_d, fin_hi_d;
  logic [3:0]       fin_flags_d;
  logic             fin_dz_d;
  logic [WIDTH:0]   mul_sum;

`ifdef ARM_MULDIV_DIV_EN
  localparam logic [1:0]       OP_UDIV  = 2'b10;
  localparam logic [1:0]       OP_SDIV  = 2'b11;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Original dividend and divisor sign are kept for sign correction and divide-by-zero.
  logic [WIDTH-1:0] a_q;
  logic             neg_b_q;
  logic [WIDTH:0]   div_shift, div_trial;
  logic [WIDTH-1:0] quot, rem;
  logic             ovf;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic signed_en);
    return (signed_en && v[WIDTH-1]) ? neg2c(v) : v;
  endfunction
`endif

  // One iteration of the shared shift-add / restoring-subtract datapath.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    step_hi_d = mul_sum[WIDTH:1];
    step_lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ARM_MULDIV_DIV_EN
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, mcand_q};
    if (op_q[1]) begin
      if (div_trial[WIDTH]) begin
        step_hi_d = div_shift[WIDTH-1:0];
        step_lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        step_hi_d = div_trial[WIDTH-1:0];
        step_lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_hi_d = mul_sum[WIDTH:1];
      step_lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
`endif
  end

  // Final result, sign correction and flags, registered in FIN.
  always_comb begin
    fin_lo_d    = lo_q;
    fin_hi_d    = hi_q;
    fin_dz_d    = 1'b0;
    fin_flags_d = 4'b0000;
`ifdef ARM_MULDIV_DIV_EN
    quot = lo_q;
    rem  = hi_q;
    ovf  = 1'b0;
`endif
    case (op_q)
      OP_MUL:   fin_flags_d = {lo_q[WIDTH-1], lo_q == ZERO, 2'b00};
      OP_UMULL: fin_flags_d = {hi_q[WIDTH-1], {hi_q, lo_q} == {ZERO, ZERO}, 2'b00};
`ifdef ARM_MULDIV_DIV_EN
      OP_UDIV, OP_SDIV: begin
        if (mcand_q == ZERO) begin
          fin_lo_d    = ZERO;
          fin_hi_d    = a_q;
          fin_dz_d    = 1'b1;
          fin_flags_d = 4'b0100;
        end else begin
          quot = (op_q == OP_SDIV && (a_q[WIDTH-1] ^ neg_b_q)) ? neg2c(lo_q) : lo_q;
          rem  = (op_q == OP_SDIV && a_q[WIDTH-1]) ? neg2c(hi_q) : hi_q;
          ovf  = (op_q == OP_SDIV) && (a_q == MOST_NEG) && neg_b_q && (mcand_q == ONE);
          fin_lo_d    = quot;
          fin_hi_d    = rem;
          fin_flags_d = {quot[WIDTH-1], quot == ZERO, 1'b0, ovf};
        end
      end
`endif
      default: begin
        fin_lo_d    = ZERO;
        fin_hi_d    = ZERO;
        fin_flags_d = 4'b0000;
      end
    endcase
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      mcand_q   <= ZERO;
      hi_q      <= ZERO;
      lo_q      <= ZERO;
      cnt_q     <= {CW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      illegal_q <= 1'b0;
      res_lo_q  <= ZERO;
      res_hi_q  <= ZERO;
      flags_q   <= 4'b0000;
`ifdef ARM_MULDIV_DIV_EN
      a_q       <= ZERO;
      neg_b_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q   <= op_i;
            hi_q   <= ZERO;
            cnt_q  <= CNT_INIT;
            busy_q <= 1'b1;
`ifdef ARM_MULDIV_DIV_EN
            mcand_q <= op_i[1] ? mag(b_i, op_i[0]) : a_i;
            lo_q    <= op_i[1] ? mag(a_i, op_i[0]) : b_i;
            a_q     <= a_i;
            neg_b_q <= b_i[WIDTH-1];
            state_q <= S_RUN;
`else
            if (op_i[1]) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
              divzero_q <= 1'b0;
              res_lo_q  <= ZERO;
              res_hi_q  <= ZERO;
              flags_q   <= 4'b0000;
            end else begin
              mcand_q <= a_i;
              lo_q    <= b_i;
              state_q <= S_RUN;
            end
`endif
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_RUN: begin
          hi_q  <= step_hi_d;
          lo_q  <= step_lo_d;
          cnt_q <= cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIN;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_FIN: begin
          res_lo_q  <= fin_lo_d;
          res_hi_q  <= fin_hi_d;
          flags_q   <= fin_flags_d;
          divzero_q <= fin_dz_d;
          illegal_q <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          divzero_q <= 1'b0;
          illegal_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_lo_o = res_lo_q;
  assign result_hi_o = res_hi_q;
  assign flags_o     = flags_q;
  assign divzero_o   = divzero_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_arm_muldiv_unit.sv
// Self-checking bench for arm_muldiv_unit (WIDTH=32) against an arithmetic reference model.
module tb_arm_muldiv_unit;
  localparam int W = 32;
`ifdef ARM_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] rlo, rhi;
  logic [3:0]   flags;
  logic         dz, ill;
  int checks = 0;
  int failures = 0;

  arm_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .result_lo_o(rlo), .result_hi_o(rhi),
    .flags_o(flags), .divzero_o(dz), .illegal_o(ill)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] lo, output logic [31:0] hi, output logic [3:0] fl,
                                output logic d, output logic il, output int lat);
    logic [63:0] p;
    longint sx, sy, q, r;
    lo = 32'd0; hi = 32'd0; fl = 4'd0; d = 1'b0; il = 1'b0; lat = W + 1;
    if (o[1] && !DIV_EN) begin
      il = 1'b1; lat = 0;
    end else if (!o[1]) begin
      p  = {32'd0, x} * {32'd0, y};
      lo = p[31:0]; hi = p[63:32];
      fl[3] = (o == 2'b00) ? lo[31] : hi[31];
      fl[2] = (o == 2'b00) ? (lo == 32'd0) : (p == 64'd0);
    end else if (y == 32'd0) begin
      hi = x; d = 1'b1; fl = 4'b0100;
    end else begin
      if (o == 2'b10) begin
        lo = x / y; hi = x % y;
      end else begin
        sx = longint'($signed(x)); sy = longint'($signed(y));
        q = sx / sy; r = sx % sy;
        lo = q[31:0]; hi = r[31:0];
        fl[0] = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      end
      fl[3] = lo[31]; fl[2] = (lo == 32'd0);
    end
  endfunction

  // Issue one op at the current negedge, wait for done, then sample the cycle after it.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] lo, output logic [31:0] hi,
                        output logic [3:0] fl, output logic d, output logic il,
                        output logic busy_after, output logic done_after);
    int n;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    lat = done ? n : -1;
    lo = rlo; hi = rhi; fl = flags; d = dz; il = ill;
    @(negedge clk);
    busy_after = busy; done_after = done;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, dz, ill} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got busy/done/dz/ill=%b required 0000", {busy, done, dz, ill});
    end
    checks++;
    if ({rlo, rhi, flags} !== {32'd0, 32'd0, 4'd0}) begin
      failures++;
      $display("FAIL reset_data got lo=%h hi=%h fl=%b required zeros", rlo, rhi, flags);
    end
  endtask

  task automatic test_plan_vectors();
    logic [1:0]  t_op[6] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3};
    logic [31:0] t_a[6]  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'h8000_0000};
    logic [31:0] t_b[6]  = '{32'd6, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] e_lo[6] = '{32'h2A, 32'h1, 32'hFFFF_FFFD, 32'd14, 32'd0, 32'h8000_0000};
    logic [31:0] e_hi[6] = '{32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2, 32'd100, 32'd0};
    logic [3:0]  e_fl[6] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0100, 4'b1001};
    logic        e_dz[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] lo, hi, xlo, xhi;
    logic [3:0]  fl, xfl;
    logic        d, il, ba, da, xd, xil;
    int          lat, xlat;
    for (int i = 0; i < 6; i++) begin
      xlo = e_lo[i]; xhi = e_hi[i]; xfl = e_fl[i]; xd = e_dz[i]; xil = 1'b0; xlat = 33;
      if (t_op[i][1] && !DIV_EN) begin
        xlo = 32'd0; xhi = 32'd0; xfl = 4'd0; xd = 1'b0; xil = 1'b1; xlat = 0;
      end
      run_op(t_op[i], t_a[i], t_b[i], lat, lo, hi, fl, d, il, ba, da);
      checks++;
      if (lat != xlat || {lo, hi, fl, d, il} !== {xlo, xhi, xfl, xd, xil}) begin
        failures++;
        $display("FAIL plan[%0d] got lat=%0d lo=%h hi=%h fl=%b dz=%b il=%b required lat=%0d lo=%h hi=%h fl=%b dz=%b il=%b",
                 i, lat, lo, hi, fl, d, il, xlat, xlo, xhi, xfl, xd, xil);
      end
      checks++;
      if ({ba, da} !== 2'b00) begin
        failures++;
        $display("FAIL plan_busy_fall[%0d] got busy/done=%b required 00", i, {ba, da});
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y, lo, hi, xlo, xhi;
    logic [3:0]  fl, xfl;
    logic        d, il, ba, da, xd, xil;
    int          lat, xlat, k;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom; y = $urandom;
      k = $urandom_range(0, 7);
      if (k == 0) y = 32'd0;
      else if (k == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (k == 2) begin x = 32'($urandom_range(0, 300)); y = 32'($urandom_range(1, 20)); end
      else if (k == 3) y = -32'($urandom_range(1, 9));
      model(o, x, y, xlo, xhi, xfl, xd, xil, xlat);
      run_op(o, x, y, lat, lo, hi, fl, d, il, ba, da);
      checks++;
      if (lat != xlat || {lo, hi, fl, d, il, ba, da} !== {xlo, xhi, xfl, xd, xil, 2'b00}) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got lat=%0d lo=%h hi=%h fl=%b dz=%b il=%b bsy=%b required lat=%0d lo=%h hi=%h fl=%b dz=%b il=%b",
                 i, o, x, y, lat, lo, hi, fl, d, il, ba, xlat, xlo, xhi, xfl, xd, xil);
      end
    end
  endtask

  task automatic test_ignored_start();
    int ndone, dn;
    logic [31:0] dlo;
    logic bpost;
    ndone = 0; dn = -1; dlo = 32'd0; bpost = 1'b1;
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6;
    @(negedge clk);
    for (int n = 0; n < 60; n++) begin
      if (done) begin ndone++; dn = n; dlo = rlo; end
      if (n == dn + 1) bpost = busy;
      start = (n == 5) || done;
      op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (ndone != 1 || dn != 33) begin
      failures++;
      $display("FAIL ignored_start_done got pulses=%0d at=%0d required 1 at 33", ndone, dn);
    end
    checks++;
    if (dlo !== 32'd42 || rlo !== 32'd42 || rhi !== 32'd0) begin
      failures++;
      $display("FAIL ignored_start_result got lo=%h held=%h hi=%h required 2a/2a/0", dlo, rlo, rhi);
    end
    checks++;
    if (bpost !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignored_start_busy got post=%b end=%b required 0/0", bpost, busy);
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] lo, hi;
    logic [3:0]  fl;
    logic        d, il, ba, da;
    int          lat;
    start = 1'b1; op = 2'b01; a = 32'h1234_5678; b = 32'h9ABC_DEF1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, dz, ill, rlo, rhi, flags} !== {4'b0000, 32'd0, 32'd0, 4'd0}) begin
      failures++;
      $display("FAIL reset_midrun got busy=%b done=%b lo=%h hi=%h fl=%b required zeros", busy, done, rlo, rhi, flags);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(2'b00, 32'd3, 32'd5, lat, lo, hi, fl, d, il, ba, da);
    checks++;
    if (lat != 33 || {lo, hi, fl, d, il, ba} !== {32'd15, 32'd0, 4'd0, 3'b000}) begin
      failures++;
      $display("FAIL after_reset_mul got lat=%0d lo=%h hi=%h fl=%b busy=%b required 33/f/0/0000/0", lat, lo, hi, fl, ba);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y, lo, hi, xlo, xhi, plo, phi;
    logic [3:0]  fl, xfl;
    logic        d, il, ba, da, xd, xil;
    int          lat, xlat;
    for (int i = 0; i < 4; i++) begin
      x = $urandom; y = $urandom;
      model(2'(i), x, y, xlo, xhi, xfl, xd, xil, xlat);
      run_op(2'(i), x, y, lat, lo, hi, fl, d, il, ba, da);
      checks++;
      if (lat != xlat || {lo, hi, fl, d, il} !== {xlo, xhi, xfl, xd, xil}) begin
        failures++;
        $display("FAIL back_to_back[%0d] got lat=%0d lo=%h hi=%h fl=%b required lat=%0d lo=%h hi=%h fl=%b",
                 i, lat, lo, hi, fl, xlat, xlo, xhi, xfl);
      end
    end
    plo = rlo; phi = rhi;
    repeat (3) @(negedge clk);
    checks++;
    if ({rlo, rhi} !== {plo, phi} || rlo !== xlo) begin
      failures++;
      $display("FAIL result_hold got lo=%h hi=%h required lo=%h hi=%h", rlo, rhi, xlo, xhi);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_plan_vectors();
    test_ignored_start();
    @(negedge clk);
    test_reset_midrun();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
